// File: rtl/next_state_writeback.sv
// Write side of the frame pipeline: buffers computed rows in a 2-entry FIFO,
// writes them into the write-frame BRAM and handshakes the frame-buffer swap.
module next_state_writeback #(
  parameter int X_SIZE  = 1280,
  parameter int Y_SIZE  = 720,
  parameter int Y_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_row_valid,
  output logic               o_row_ready,
  input  logic [X_SIZE-1:0]  i_row_data,
  input  logic [Y_WIDTH-1:0] i_row_index,
  input  logic               i_wr_grant,
  output logic               o_wr_en,
  output logic [Y_WIDTH-1:0] o_wr_addr,
  output logic [X_SIZE-1:0]  o_wr_data,
  output logic               o_frame_done,
  input  logic               i_swap_ack,
  output logic [Y_WIDTH-1:0] o_rows_written,
  output logic               o_row_error
);

  localparam logic [Y_WIDTH-1:0] Y_LIMIT = Y_WIDTH'(Y_SIZE);
  localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(Y_SIZE - 1);

  typedef enum logic [1:0] {STREAM, SWAP, WAIT_ACK} state_t;

  state_t               r_state, w_next_state;
  logic [Y_WIDTH-1:0]   r_idx  [2];
  logic [X_SIZE-1:0]    r_data [2];
  logic                 r_rd_ptr, r_wr_ptr;
  logic [1:0]           r_count;
  logic [Y_WIDTH-1:0]   r_expected_row;
  logic [Y_WIDTH-1:0]   r_rows_written;
  logic                 r_row_error;

  logic                 w_push, w_pop, w_write, w_drop;
  logic                 w_nonempty, w_in_range;
  logic [Y_WIDTH-1:0]   w_head_idx;

  assign o_row_ready = (r_count != 2'd2);
  assign w_push      = i_row_valid & o_row_ready;
  assign w_nonempty  = (r_count != 2'd0);
  assign w_head_idx  = r_idx[r_rd_ptr];
  assign w_in_range  = (w_head_idx < Y_LIMIT);
  assign w_pop       = w_write | w_drop;

  assign o_wr_en        = w_write;
  assign o_wr_addr      = w_nonempty ? w_head_idx : '0;
  assign o_wr_data      = w_nonempty ? r_data[r_rd_ptr] : '0;
  assign o_frame_done   = (r_state == SWAP);
  assign o_rows_written = r_rows_written;
  assign o_row_error    = r_row_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= STREAM;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      STREAM: begin
        if (w_nonempty) begin
          if (w_in_range) begin
            w_write = i_wr_grant;
            if (w_write && (w_head_idx == Y_LAST)) w_next_state = SWAP;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      SWAP:     w_next_state = WAIT_ACK;
      WAIT_ACK: if (i_swap_ack) w_next_state = STREAM;
      default:  w_next_state = STREAM;
    endcase
  end

  // NOTE: the entry storage has no reset; an empty FIFO is defined by
  // r_count alone and the outputs are gated with it, so stale contents
  // never escape.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx[r_wr_ptr]  <= i_row_index;
      r_data[r_wr_ptr] <= i_row_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected_row <= '0;
      r_rows_written <= '0;
      r_row_error    <= 1'b0;
    end else begin
      if (w_write) begin
        if (w_head_idx != r_expected_row) r_row_error <= 1'b1;
        r_expected_row <= w_head_idx + 1'b1;
        if (r_rows_written < Y_LIMIT) r_rows_written <= r_rows_written + 1'b1;
      end
      if (w_drop) r_row_error <= 1'b1;
      // Counters restart on the same edge the top level acknowledges the swap.
      if ((r_state == WAIT_ACK) && i_swap_ack) begin
        r_expected_row <= '0;
        r_rows_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_next_state_writeback.sv
// Directed bench for next_state_writeback: a per-cycle vector table for grant
// backpressure plus hand-written sequences for frame, swap, error and reset cases.
module tb_next_state_writeback;
  localparam int X_SIZE  = 1280;
  localparam int Y_SIZE  = 720;
  localparam int Y_WIDTH = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_row_valid = 1'b0;
  logic               o_row_ready;
  logic [X_SIZE-1:0]  i_row_data = '0;
  logic [Y_WIDTH-1:0] i_row_index = '0;
  logic               i_wr_grant = 1'b0;
  logic               o_wr_en;
  logic [Y_WIDTH-1:0] o_wr_addr;
  logic [X_SIZE-1:0]  o_wr_data;
  logic               o_frame_done;
  logic               i_swap_ack = 1'b0;
  logic [Y_WIDTH-1:0] o_rows_written;
  logic               o_row_error;

  next_state_writeback #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .Y_WIDTH(Y_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_row_valid(i_row_valid), .o_row_ready(o_row_ready),
    .i_row_data(i_row_data), .i_row_index(i_row_index),
    .i_wr_grant(i_wr_grant), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_done(o_frame_done), .i_swap_ack(i_swap_ack),
    .o_rows_written(o_rows_written), .o_row_error(o_row_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [Y_WIDTH-1:0] log_addr[$];
  logic [X_SIZE-1:0]  log_data[$];
  int                 fd_cyc[$];
  int                 exp_q[$];
  int                 cyc = 0;
  int                 wr_last_cyc = -1;

  typedef struct {
    logic               valid;
    logic [Y_WIDTH-1:0] idx;
    logic               grant;
    logic               exp_ready;
    logic               exp_wr_en;
    logic [Y_WIDTH-1:0] exp_addr;
    logic [Y_WIDTH-1:0] exp_rows;
  } vec_t;

  vec_t vecs[7];

  // Inputs change just after posedge, so the negedge value is what the BRAM sees.
  always @(negedge clk) begin
    cyc++;
    if (o_wr_en) begin
      log_addr.push_back(o_wr_addr);
      log_data.push_back(o_wr_data);
      if (o_wr_addr == Y_WIDTH'(Y_SIZE - 1)) wr_last_cyc = cyc;
    end
    if (o_frame_done) fd_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [X_SIZE-1:0] pat(input int idx);
    logic [X_SIZE-1:0] r;
    for (int k = 0; k < X_SIZE / 32; k++)
      r[k*32 +: 32] = (32'h9E37_79B9 * 32'(idx + 1)) ^ 32'(k);
    return r;
  endfunction

  function automatic vec_t mk(input bit v, input int idx, input bit g,
                              input bit r, input bit we, input int addr, input int rows);
    vec_t t;
    t.valid = v; t.idx = Y_WIDTH'(idx); t.grant = g;
    t.exp_ready = r; t.exp_wr_en = we; t.exp_addr = Y_WIDTH'(addr); t.exp_rows = Y_WIDTH'(rows);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); fd_cyc.delete(); exp_q.delete();
    wr_last_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_row_valid = 1'b0; i_wr_grant = 1'b0; i_swap_ack = 1'b0;
    i_row_index = '0; i_row_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
  endtask

  // Offer one row and hold it until accepted; a bounded wait counts as a failure.
  task automatic send(input int idx);
    int budget = 50;
    i_row_valid = 1'b1;
    i_row_index = Y_WIDTH'(idx);
    i_row_data  = pat(idx);
    #1;
    while (!o_row_ready && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    if (budget == 0) check("send_timeout", 32'(idx), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    i_row_valid = 1'b0;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 32'(log_addr.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
      check({name, "_addr"}, 32'(log_addr[i]), 32'(exp_q[i]));
      check({name, "_data"}, 32'(log_data[i] == pat(exp_q[i])), 32'd1);
    end
  endtask

  task automatic full_frame(input string name);
    i_wr_grant = 1'b1;
    for (int r = 0; r < Y_SIZE; r++) send(r);
    step(4);
    for (int r = 0; r < Y_SIZE; r++) exp_q.push_back(r);
    check_log(name);
    check({name, "_fd_count"}, 32'(fd_cyc.size()), 32'd1);
    if (fd_cyc.size() > 0) check({name, "_fd_timing"}, 32'(fd_cyc[0]), 32'(wr_last_cyc + 1));
    check({name, "_rows"}, 32'(o_rows_written), 32'(Y_SIZE));
    check({name, "_err"}, 32'(o_row_error), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(1, 0, 0, 1, 0, 0, 0);
    vecs[1] = mk(1, 1, 0, 1, 0, 0, 0);
    vecs[2] = mk(1, 2, 0, 0, 0, 0, 0);
    vecs[3] = mk(1, 2, 1, 0, 1, 0, 0);
    vecs[4] = mk(1, 2, 1, 1, 1, 1, 1);
    vecs[5] = mk(0, 0, 1, 1, 1, 2, 2);
    vecs[6] = mk(0, 0, 1, 1, 0, 0, 3);

    // Reset state
    do_reset();
    check("rst_ready", 32'(o_row_ready), 32'd1);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data == '0), 32'd1);
    check("rst_rows", 32'(o_rows_written), 32'd0);
    check("rst_err", 32'(o_row_error), 32'd0);
    check("rst_fd", 32'(o_frame_done), 32'd0);

    // Grant backpressure, one table row per cycle
    for (int i = 0; i < 7; i++) begin
      i_row_valid = vecs[i].valid;
      i_row_index = vecs[i].idx;
      i_row_data  = pat(int'(vecs[i].idx));
      i_wr_grant  = vecs[i].grant;
      #1;
      check($sformatf("bp%0d_ready", i), 32'(o_row_ready), 32'(vecs[i].exp_ready));
      check($sformatf("bp%0d_wr_en", i), 32'(o_wr_en), 32'(vecs[i].exp_wr_en));
      check($sformatf("bp%0d_addr", i), 32'(o_wr_addr), 32'(vecs[i].exp_addr));
      check($sformatf("bp%0d_rows", i), 32'(o_rows_written), 32'(vecs[i].exp_rows));
      if (vecs[i].exp_wr_en)
        check($sformatf("bp%0d_data", i), 32'(o_wr_data == pat(int'(vecs[i].exp_addr))), 32'd1);
      @(posedge clk); #1;
    end
    i_row_valid = 1'b0;
    exp_q = '{0, 1, 2};
    check_log("bp_log");
    check("bp_err", 32'(o_row_error), 32'd0);

    // Order error
    do_reset();
    i_wr_grant = 1'b1;
    send(0); send(1); step(3);
    check("ord_err_before", 32'(o_row_error), 32'd0);
    send(5); step(3);
    check("ord_err_set", 32'(o_row_error), 32'd1);
    send(6); step(3);
    check("ord_err_sticky", 32'(o_row_error), 32'd1);
    check("ord_rows", 32'(o_rows_written), 32'd4);
    exp_q = '{0, 1, 5, 6};
    check_log("ord_log");

    // Range error
    do_reset();
    i_wr_grant = 1'b1;
    send(800); step(3);
    check("rng_no_write", 32'(log_addr.size()), 32'd0);
    check("rng_err", 32'(o_row_error), 32'd1);
    check("rng_ready", 32'(o_row_ready), 32'd1);
    send(0); step(3);
    exp_q = '{0};
    check_log("rng_log");
    check("rng_rows", 32'(o_rows_written), 32'd1);

    // In-order frame, then swap handshake from WAIT_ACK
    do_reset();
    full_frame("frame1");
    clear_log();
    i_swap_ack = 1'b0;
    send(0); send(1);
    i_row_valid = 1'b1; i_row_index = Y_WIDTH'(2); i_row_data = pat(2);
    #1;
    check("swp_ready_full", 32'(o_row_ready), 32'd0);
    step(10);
    check("swp_no_write", 32'(log_addr.size()), 32'd0);
    check("swp_ready_hold", 32'(o_row_ready), 32'd0);
    check("swp_rows_hold", 32'(o_rows_written), 32'(Y_SIZE));
    check("swp_fd_low", 32'(o_frame_done), 32'd0);
    i_row_valid = 1'b0;
    i_swap_ack = 1'b1;
    step(1);
    i_swap_ack = 1'b0;
    #1;
    check("swp_rows0", 32'(o_rows_written), 32'd0);
    check("swp_wr_en", 32'(o_wr_en), 32'd1);
    check("swp_addr0", 32'(o_wr_addr), 32'd0);
    step(1);
    check("swp_rows1", 32'(o_rows_written), 32'd1);
    step(1);
    check("swp_rows2", 32'(o_rows_written), 32'd2);
    exp_q = '{0, 1};
    check_log("swp_log");
    check("swp_err", 32'(o_row_error), 32'd0);

    // Async reset mid-frame with a full FIFO
    do_reset();
    i_wr_grant = 1'b1;
    send(0); send(7); step(2);
    check("ar_pre_rows", 32'(o_rows_written), 32'd2);
    check("ar_pre_err", 32'(o_row_error), 32'd1);
    i_wr_grant = 1'b0;
    send(8); send(9);
    check("ar_pre_full", 32'(o_row_ready), 32'd0);
    i_wr_grant = 1'b1;
    #1;
    check("ar_pre_wr_en", 32'(o_wr_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_wr_en", 32'(o_wr_en), 32'd0);
    check("ar_err", 32'(o_row_error), 32'd0);
    check("ar_fd", 32'(o_frame_done), 32'd0);
    check("ar_rows", 32'(o_rows_written), 32'd0);
    check("ar_addr", 32'(o_wr_addr), 32'd0);
    check("ar_ready", 32'(o_row_ready), 32'd1);
    clear_log();
    repeat (2) @(posedge clk);
    check("ar_held_no_write", 32'(log_addr.size()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    check("ar_post_ready", 32'(o_row_ready), 32'd1);
    full_frame("frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
